// File: rtl/roach_clk_rst_sequencer_if.sv
// roach_clk_rst_sequencer_if: lock/ready inputs, restart and reset/status outputs of the clock-reset sequencer
interface roach_clk_rst_sequencer_if;
    logic       sys_clk_lock;
    logic       aux_clk_lock;
    logic       idelay_rdy;
    logic       restart;
    logic       mmcm_reset;
    logic       idelay_rst;
    logic       sys_rst;
    logic       seq_done;
    logic       seq_fail;
    logic [2:0] state;
    logic [7:0] retry_count;
    logic [7:0] relock_count;
    modport master (
        input  sys_clk_lock, aux_clk_lock, idelay_rdy, restart,
        output mmcm_reset, idelay_rst, sys_rst, seq_done, seq_fail, state, retry_count, relock_count
    );
    modport slave (
        output sys_clk_lock, aux_clk_lock, idelay_rdy, restart,
        input  mmcm_reset, idelay_rst, sys_rst, seq_done, seq_fail, state, retry_count, relock_count
    );
endinterface

// File: rtl/roach_clk_rst_sequencer.sv
// roach_clk_rst_sequencer: MMCM/IDELAYCTRL reset sequencing with lock timeouts, bounded retries and lock-loss recovery
module roach_clk_rst_sequencer #(
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int IDLY_RST_CYCLES = 64,
    parameter int SETTLE_CYCLES   = 256,
    parameter int MAX_RETRY       = 4,
    parameter int LOSS_FILTER     = 4,
    parameter int USE_AUX         = 1
) (
    input logic                       epb_clk,
    input logic                       epb_rst_n,
    roach_clk_rst_sequencer_if.master seq
);
    localparam int T1   = RST_CYCLES > IDLY_RST_CYCLES ? RST_CYCLES : IDLY_RST_CYCLES;
    localparam int T2   = SETTLE_CYCLES > LOCK_TIMEOUT ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX = T1 > T2 ? T1 : T2;
    localparam int TW   = $clog2(TMAX);
    localparam int LW   = $clog2(LOSS_FILTER + 1);

    typedef enum logic [2:0] {
        MMCM_RST  = 3'd0,
        WAIT_LOCK = 3'd1,
        IDLY_RST  = 3'd2,
        WAIT_RDY  = 3'd3,
        SETTLE    = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] loss_q, loss_d;
    logic [7:0]    retry_q, retry_d, relock_q, relock_d;
    logic [2:0]    sync1_q, sync2_q;
    logic          mmcm_reset_q, mmcm_reset_d, idelay_rst_q, idelay_rst_d, sys_rst_q, sys_rst_d;
    logic          seq_done_q, seq_done_d, seq_fail_q, seq_fail_d;
    logic          lock_ok, timeout, fault;

    always_comb begin
        lock_ok  = sync2_q[2] & (sync2_q[1] | (USE_AUX == 0));
        timeout  = timer_q == TW'(LOCK_TIMEOUT - 1);
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        loss_d   = '0;
        fault    = 1'b0;
        if (seq.restart) begin
            state_d = MMCM_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                MMCM_RST:  if (timer_q == TW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                WAIT_LOCK: if (timeout) fault = 1'b1; else if (lock_ok) state_d = IDLY_RST;
                IDLY_RST:  if (!lock_ok) fault = 1'b1; else if (timer_q == TW'(IDLY_RST_CYCLES - 1)) state_d = WAIT_RDY;
                WAIT_RDY:  if (!lock_ok || timeout) fault = 1'b1; else if (sync2_q[0]) state_d = SETTLE;
                SETTLE:    if (!lock_ok) fault = 1'b1; else if (timer_q == TW'(SETTLE_CYCLES - 1)) state_d = RUN;
                RUN: begin
                    if (!lock_ok && loss_q == LW'(LOSS_FILTER - 1)) begin
                        state_d  = MMCM_RST;
                        retry_d  = '0;
                        relock_d = relock_q + {7'd0, relock_q != 8'hff};
                    end else begin
                        loss_d = lock_ok ? '0 : loss_q + LW'(1);
                    end
                end
                default: ;
            endcase
            // a timeout or an early lock drop consumes one retry, or gives up once the budget is spent
            if (fault) begin
                state_d = (retry_q < 8'(MAX_RETRY)) ? MMCM_RST : FAIL;
                retry_d = (retry_q < 8'(MAX_RETRY)) ? retry_q + 8'd1 : retry_q;
            end
        end
        timer_d      = (seq.restart || state_d != state_q) ? '0 :
                       (timer_q == TW'(TMAX - 1)) ? timer_q : timer_q + TW'(1);
        mmcm_reset_d = state_d == MMCM_RST;
        idelay_rst_d = state_d inside {MMCM_RST, WAIT_LOCK, IDLY_RST, FAIL};
        sys_rst_d    = state_d != RUN;
        seq_done_d   = state_d == RUN;
        seq_fail_d   = state_d == FAIL;
    end

    always_ff @(posedge epb_clk) begin
        if (!epb_rst_n) begin
            state_q      <= MMCM_RST;
            timer_q      <= '0;
            loss_q       <= '0;
            retry_q      <= '0;
            relock_q     <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            mmcm_reset_q <= 1'b1;
            idelay_rst_q <= 1'b1;
            sys_rst_q    <= 1'b1;
            seq_done_q   <= 1'b0;
            seq_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            loss_q       <= loss_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            sync1_q      <= {seq.sys_clk_lock, seq.aux_clk_lock, seq.idelay_rdy};
            sync2_q      <= sync1_q;
            mmcm_reset_q <= mmcm_reset_d;
            idelay_rst_q <= idelay_rst_d;
            sys_rst_q    <= sys_rst_d;
            seq_done_q   <= seq_done_d;
            seq_fail_q   <= seq_fail_d;
        end
    end

    assign seq.mmcm_reset   = mmcm_reset_q;
    assign seq.idelay_rst   = idelay_rst_q;
    assign seq.sys_rst      = sys_rst_q;
    assign seq.seq_done     = seq_done_q;
    assign seq.seq_fail     = seq_fail_q;
    assign seq.state        = state_q;
    assign seq.retry_count  = retry_q;
    assign seq.relock_count = relock_q;
endmodule

// File: tb/tb_roach_clk_rst_sequencer.sv
// tb_roach_clk_rst_sequencer: scoreboard bench, USE_AUX=1 and USE_AUX=0 instances driven by an emulated MMCM/IDELAYCTRL
module tb_roach_clk_rst_sequencer;
    localparam int RC = 4, LT = 32, IC = 8, SC = 16, MR = 2, LF = 3;
    localparam int NEVER = 1 << 30;

    typedef struct packed {
        logic [2:0] st;
        logic       mr, ir, sr, dn, fl;
        logic [7:0] rc, lc;
    } obs_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sys = 1'b0, aux = 1'b0, rdy = 1'b0, restart = 1'b0;
    int   vectors = 0, errors = 0;
    int   sys_dly = 10, aux_dly = 10, rdy_dly = 5, sys_cnt = 0, rdy_cnt = 0, glitch = 0;
    bit   noise = 0;
    obs_t q0[$], q1[$];

    int       m_st[2], m_dw[2], m_rt[2], m_rl[2];
    bit [31:0] m_okh[2];
    bit [1:0] m_lk[2], m_rd[2];

    always #5 clk = ~clk;

    roach_clk_rst_sequencer_if b0(), b1();
    assign b0.sys_clk_lock = sys;
    assign b0.aux_clk_lock = aux;
    assign b0.idelay_rdy   = rdy;
    assign b0.restart      = restart;
    assign b1.sys_clk_lock = sys;
    assign b1.aux_clk_lock = aux;
    assign b1.idelay_rdy   = rdy;
    assign b1.restart      = restart;

    roach_clk_rst_sequencer #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .IDLY_RST_CYCLES(IC), .SETTLE_CYCLES(SC),
        .MAX_RETRY(MR), .LOSS_FILTER(LF), .USE_AUX(1)) dut0 (.epb_clk(clk), .epb_rst_n(rst_n), .seq(b0));
    roach_clk_rst_sequencer #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .IDLY_RST_CYCLES(IC), .SETTLE_CYCLES(SC),
        .MAX_RETRY(MR), .LOSS_FILTER(LF), .USE_AUX(0)) dut1 (.epb_clk(clk), .epb_rst_n(rst_n), .seq(b1));

    // Reference: m_dw counts cycles spent in the current state; lock history sits in m_okh.
    task automatic model_step(input int i);
        bit   ok, rd, flt;
        int   nx;
        obs_t e;
        ok = m_lk[i][1];
        rd = m_rd[i][1];
        m_lk[i] = {m_lk[i][0], sys & (aux | (i == 1))};
        m_rd[i] = {m_rd[i][0], rdy};
        if (!rst_n) begin
            m_st[i] = 0; m_dw[i] = 1; m_rt[i] = 0; m_rl[i] = 0; m_lk[i] = 0; m_rd[i] = 0; m_okh[i] = '1;
        end else begin
            nx = m_st[i];
            flt = 0;
            m_okh[i] = {m_okh[i][30:0], ok};
            if (restart) begin
                nx = 0;
                m_rt[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (m_dw[i] == RC) nx = 1;
                    1: if (m_dw[i] == LT) flt = 1; else if (ok) nx = 2;
                    2: if (!ok) flt = 1; else if (m_dw[i] == IC) nx = 3;
                    3: if (!ok || m_dw[i] == LT) flt = 1; else if (rd) nx = 4;
                    4: if (!ok) flt = 1; else if (m_dw[i] == SC) nx = 5;
                    5: if (m_dw[i] >= LF && m_okh[i][LF-1:0] == 0) begin
                        nx = 0;
                        m_rt[i] = 0;
                        m_rl[i] = m_rl[i] < 255 ? m_rl[i] + 1 : 255;
                    end
                    default: ;
                endcase
                if (flt && m_rt[i] < MR) begin
                    nx = 0;
                    m_rt[i]++;
                end else if (flt) nx = 6;
            end
            m_dw[i] = (nx != m_st[i] || restart) ? 1 : m_dw[i] + 1;
            m_st[i] = nx;
        end
        e = '{st: 3'(m_st[i]), mr: m_st[i] == 0, ir: m_st[i] inside {0, 1, 2, 6}, sr: m_st[i] != 5,
              dn: m_st[i] == 5, fl: m_st[i] == 6, rc: 8'(m_rt[i]), lc: 8'(m_rl[i])};
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    always @(posedge clk) for (int i = 0; i < 2; i++) model_step(i);

    task automatic check(input int i, input obs_t e, input obs_t a);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d outputs @%0t: got st=%0d mr=%b ir=%b sr=%b done=%b fail=%b retry=%0d relock=%0d, expected st=%0d mr=%b ir=%b sr=%b done=%b fail=%b retry=%0d relock=%0d",
                     i, $time, a.st, a.mr, a.ir, a.sr, a.dn, a.fl, a.rc, a.lc, e.st, e.mr, e.ir, e.sr, e.dn, e.fl, e.rc, e.lc);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) check(0, q0.pop_front(), {b0.state, b0.mmcm_reset, b0.idelay_rst, b0.sys_rst,
                                                     b0.seq_done, b0.seq_fail, b0.retry_count, b0.relock_count});
        if (q1.size() > 0) check(1, q1.pop_front(), {b1.state, b1.mmcm_reset, b1.idelay_rst, b1.sys_rst,
                                                     b1.seq_done, b1.seq_fail, b1.retry_count, b1.relock_count});
    end

    // MMCM/IDELAYCTRL emulation follows dut0's reset outputs; glitch forces sys lock low for that many cycles.
    task automatic tick;
        @(posedge clk);
        #1;
        sys_cnt = b0.mmcm_reset ? 0 : (sys_cnt < NEVER ? sys_cnt + 1 : sys_cnt);
        rdy_cnt = b0.idelay_rst ? 0 : (rdy_cnt < NEVER ? rdy_cnt + 1 : rdy_cnt);
        if (noise) begin
            sys = $urandom_range(0, 15) != 0;
            aux = $urandom_range(0, 15) != 0;
            rdy = $urandom_range(0, 1) != 0;
        end else begin
            sys = sys_cnt >= sys_dly && glitch == 0;
            aux = sys_cnt >= aux_dly;
            rdy = rdy_cnt >= rdy_dly;
        end
        if (glitch > 0) glitch--;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        tick;
        restart = 1'b0;
    endtask

    task automatic wait_state(input int s, input string what);
        int n = 0;
        while (b0.state != 3'(s) && n < 500) begin
            tick;
            n++;
        end
        vectors++;
        if (b0.state != 3'(s)) begin
            errors++;
            $display("FAIL wait %s: state=%0d, required %0d within 500 cycles", what, b0.state, s);
        end
    endtask

    task automatic nominal(input bit fixed);
        sys_dly = fixed ? 10 : $urandom_range(2, 20);
        aux_dly = fixed ? 10 : $urandom_range(2, 20);
        rdy_dly = fixed ? 5 : $urandom_range(1, 12);
    endtask

    initial begin
        nominal(1);
        repeat (3) tick;
        rst_n = 1'b1;
        wait_state(5, "nominal");
        repeat (10) tick;
        for (int k = 0; k < 3; k++) begin
            nominal(0);
            pulse_restart;
            wait_state(5, "random nominal");
            repeat (5) tick;
        end
        for (int k = 0; k < 8; k++) begin
            glitch = (k % 2 == 0) ? $urandom_range(1, LF - 1) : $urandom_range(LF, LF + 2);
            repeat (glitch + 4) tick;
            wait_state(5, "relock");
            repeat ($urandom_range(2, 10)) tick;
        end
        sys_dly = NEVER;
        aux_dly = NEVER;
        pulse_restart;
        wait_state(6, "locks low");
        repeat (10) tick;
        nominal(1);
        pulse_restart;
        wait_state(5, "restart from fail");
        sys_dly = 5;
        aux_dly = NEVER;
        pulse_restart;
        wait_state(6, "aux low");
        repeat (10) tick;
        nominal(0);
        pulse_restart;
        wait_state(4, "settle");
        repeat ($urandom_range(0, 8)) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        wait_state(5, "after reset in settle");
        noise = 1;
        for (int k = 0; k < 1500; k++) begin
            restart = $urandom_range(0, 63) == 0;
            rst_n = $urandom_range(0, 199) != 0;
            tick;
        end
        noise = 0;
        restart = 1'b0;
        rst_n = 1'b0;
        nominal(1);
        tick;
        rst_n = 1'b1;
        wait_state(5, "final nominal");
        repeat (3) tick;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
